// File: rtl/line_burst_adapter.sv
// -----------------------------------------------------------------------------
// line_burst_adapter
//
// Converts one cacheline transaction from the cache side into a 4-beat burst
// on the main-memory interface. A write sends the stored line out one beat at
// a time. A read collects four beats and rebuilds the full line. Only one
// transaction runs at a time, and a write request wins over a read request.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   line_address_i    cache-side line address
//   line_read_i       line fill request, held until line_resp_o
//   line_write_i      line writeback request, held until line_resp_o
//   line_wdata_i      line to write back
//   line_rdata_o      assembled fill line, held until the next read completes
//   line_resp_o       one-cycle completion pulse
//   mem_address_o     line-aligned burst address
//   mem_read_o        burst read request
//   mem_write_o       burst write request
//   mem_wdata_o       current write beat
//   mem_rdata_i       read beat
//   mem_resp_i        per-beat handshake (read data valid / write beat taken)
// -----------------------------------------------------------------------------
module line_burst_adapter #(
   parameter int LINE_W      = 256,
   parameter int BURST_W     = 64,
   parameter int OFFSET_BITS = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        line_address_i,
   input  logic               line_read_i,
   input  logic               line_write_i,
   input  logic [LINE_W-1:0]  line_wdata_i,
   output logic [LINE_W-1:0]  line_rdata_o,
   output logic               line_resp_o,
   output logic [31:0]        mem_address_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic [BURST_W-1:0] mem_wdata_o,
   input  logic [BURST_W-1:0] mem_rdata_i,
   input  logic               mem_resp_i
);

   // The beat counter is a fixed 2 bits, so only the 256/64 geometry is legal.
   if (LINE_W != 256 || BURST_W != 64) begin : g_bad_geometry
      $error("line_burst_adapter supports only LINE_W=256 and BURST_W=64");
   end

   // Masking keeps every address bit in use and clears the line offset.
   localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   logic [1:0]          cnt;
   logic [LINE_W-1:0]   buffer;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge and ordering inside
   // the block does not matter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the line buffer is a plain register bank (not a RAM), so it is
         // cleared on reset; a discarded partial fill can never leak out later.
         state         <= IDLE;
         cnt           <= 2'd0;
         buffer        <= '0;
         line_rdata_o  <= '0;
         mem_address_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (line_write_i) begin
                  buffer        <= line_wdata_i;
                  mem_address_o <= line_address_i & ADDR_MASK;
                  cnt           <= 2'd0;
                  state         <= WRITE;
               end else if (line_read_i) begin
                  mem_address_o <= line_address_i & ADDR_MASK;
                  cnt           <= 2'd0;
                  state         <= READ;
               end
            end

            READ: begin
               if (mem_resp_i) begin
                  buffer[cnt*BURST_W +: BURST_W] <= mem_rdata_i;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     // The fill line is its own register: publish it together
                     // with the last beat so it is valid in the DONE cycle, and
                     // later write bursts reuse the buffer without touching it.
                     line_rdata_o <= {mem_rdata_i, buffer[LINE_W-BURST_W-1:0]};
                     state        <= DONE;
                  end
               end
            end

            WRITE: begin
               if (mem_resp_i) begin
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     state <= DONE;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes decode straight from the state register, so they carry no input
   // path and fall the moment reset clears the state.
   assign mem_read_o  = (state == READ);
   assign mem_write_o = (state == WRITE);
   assign line_resp_o = (state == DONE);

   // cnt wraps to 0 after the fourth beat and is 0 in IDLE, so outside a
   // write burst this shows beat 0 of the buffer.
   assign mem_wdata_o = buffer[cnt*BURST_W +: BURST_W];

endmodule

// File: tb/tb_line_burst_adapter.sv
// -----------------------------------------------------------------------------
// tb_line_burst_adapter
//
// Directed and randomized transactions against line_burst_adapter. Expected
// values come from a small transaction-level model: line-aligned address,
// line assembled from beats, beat sequence sliced from the write line, and the
// last completed fill line.
// -----------------------------------------------------------------------------
module tb_line_burst_adapter;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   line_address_i;
   logic          line_read_i;
   logic          line_write_i;
   logic [255:0]  line_wdata_i;
   logic [255:0]  line_rdata_o;
   logic          line_resp_o;
   logic [31:0]   mem_address_o;
   logic          mem_read_o;
   logic          mem_write_o;
   logic [63:0]   mem_wdata_o;
   logic [63:0]   mem_rdata_i;
   logic          mem_resp_i;

   line_burst_adapter dut (
      .clk            (clk),
      .rst            (rst),
      .line_address_i (line_address_i),
      .line_read_i    (line_read_i),
      .line_write_i   (line_write_i),
      .line_wdata_i   (line_wdata_i),
      .line_rdata_o   (line_rdata_o),
      .line_resp_o    (line_resp_o),
      .mem_address_o  (mem_address_o),
      .mem_read_o     (mem_read_o),
      .mem_write_o    (mem_write_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rdata_i    (mem_rdata_i),
      .mem_resp_i     (mem_resp_i)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [255:0] last_fill;      // model: last completed fill line
   logic [63:0]  beats [4];      // stimulus: read beats for the next read
   int           gaps  [4];      // stimulus: idle cycles before each beat

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Per-cycle checks of the memory-side strobes and the idle-side outputs.
   task automatic check_bus(input string tag, input logic rd, input logic wr,
                            input logic resp, input logic [31:0] addr);
      check({tag, ".mem_read"},  256'(mem_read_o),    256'(rd));
      check({tag, ".mem_write"}, 256'(mem_write_o),   256'(wr));
      check({tag, ".line_resp"}, 256'(line_resp_o),   256'(resp));
      check({tag, ".addr"},      256'(mem_address_o), 256'(addr));
   endtask

   // Read transaction using beats[] and gaps[]; verifies every cycle.
   task automatic do_read(input string tag, input logic [31:0] addr);
      logic [31:0]  exp_addr;
      logic [255:0] exp_line;
      exp_addr = addr - (addr % 32);
      exp_line = '0;
      for (int k = 0; k < 4; k++) exp_line = exp_line | ({192'd0, beats[k]} << (64 * k));

      line_address_i = addr;
      line_read_i    = 1'b1;
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gaps[k]; g++) begin
            check_bus({tag, ".gap"}, 1'b1, 1'b0, 1'b0, exp_addr);
            @(posedge clk); @(negedge clk);
         end
         check_bus({tag, ".beat"}, 1'b1, 1'b0, 1'b0, exp_addr);
         mem_rdata_i = beats[k];
         mem_resp_i  = 1'b1;
         @(posedge clk); @(negedge clk);
         mem_resp_i  = 1'b0;
         mem_rdata_i = {$urandom, $urandom};
      end
      check_bus({tag, ".done"}, 1'b0, 1'b0, 1'b1, exp_addr);
      check({tag, ".rdata_done"}, line_rdata_o, exp_line);
      line_read_i = 1'b0;
      last_fill   = exp_line;
      @(posedge clk); @(negedge clk);
      check({tag, ".resp_low"}, 256'(line_resp_o), 256'(1'b0));
      check({tag, ".rdata_hold"}, line_rdata_o, last_fill);
   endtask

   // Write transaction using gaps[]; also_read raises line_read_i alongside.
   task automatic do_write(input string tag, input logic [31:0] addr,
                           input logic [255:0] line, input logic also_read);
      logic [31:0] exp_addr;
      logic [63:0] exp_beat;
      exp_addr = addr - (addr % 32);

      line_address_i = addr;
      line_wdata_i   = line;
      line_write_i   = 1'b1;
      line_read_i    = also_read;
      @(posedge clk); @(negedge clk);
      line_wdata_i   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
         exp_beat = 64'(line >> (64 * k));
         for (int g = 0; g <= gaps[k]; g++) begin
            check_bus({tag, ".beat"}, 1'b0, 1'b1, 1'b0, exp_addr);
            check({tag, ".wdata"}, 256'(mem_wdata_o), 256'(exp_beat));
            check({tag, ".rdata_kept"}, line_rdata_o, last_fill);
            mem_resp_i = (g == gaps[k]);
            @(posedge clk); @(negedge clk);
            mem_resp_i = 1'b0;
         end
      end
      check_bus({tag, ".done"}, 1'b0, 1'b0, 1'b1, exp_addr);
      check({tag, ".rdata_kept"}, line_rdata_o, last_fill);
      line_write_i = 1'b0;
      line_read_i  = 1'b0;
      @(posedge clk); @(negedge clk);
      check({tag, ".resp_low"}, 256'(line_resp_o), 256'(1'b0));
   endtask

   initial begin
      rst = 1'b1;
      line_address_i = '0; line_read_i = 1'b0; line_write_i = 1'b0;
      line_wdata_i = '0; mem_rdata_i = '0; mem_resp_i = 1'b0;
      last_fill = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state
      check_bus("reset", 1'b0, 1'b0, 1'b0, 32'h0);
      check("reset.rdata", line_rdata_o, 256'd0);
      check("reset.wdata", 256'(mem_wdata_o), 256'd0);
      rst = 1'b0;
      @(posedge clk); @(negedge clk);

      // Back-to-back read at 0x1234
      beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      gaps  = '{0, 0, 0, 0};
      do_read("read_basic", 32'h0000_1234);

      // Back-to-back write at 0x8000_003F, beats A,B,C,D
      do_write("write_basic", 32'h8000_003F,
               {64'hD, 64'hC, 64'hB, 64'hA}, 1'b0);

      // Write with acceptance at cycles 3, 7, 8, 12
      gaps = '{2, 3, 0, 3};
      do_write("write_gaps", 32'h0000_0040,
               {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001}, 1'b0);

      // Read and write requested together: write runs first, read follows
      gaps = '{0, 1, 0, 0};
      do_write("write_prio", 32'h1234_5678,
               {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                64'h5555_AAAA_5555_AAAA, 64'hAAAA_5555_AAAA_5555}, 1'b1);
      beats = '{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002,
                64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0004};
      gaps  = '{1, 0, 2, 0};
      do_read("read_after_prio", 32'h1234_5678);

      // Stray mem_resp_i in IDLE
      mem_resp_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         check_bus("stray_resp", 1'b0, 1'b0, 1'b0, 32'h1234_5660);
         check("stray_resp.rdata", line_rdata_o, last_fill);
      end
      mem_resp_i = 1'b0;

      // Reset after two beats of a read
      line_address_i = 32'h0000_2000;
      line_read_i    = 1'b1;
      @(posedge clk); @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         mem_rdata_i = 64'h9999_0000_0000_0000 | 64'(k);
         mem_resp_i  = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      mem_resp_i = 1'b0;
      check("midreset.pre_read", 256'(mem_read_o), 256'(1'b1));
      rst = 1'b1;
      #1;
      check("midreset.mem_read", 256'(mem_read_o), 256'(1'b0));
      check("midreset.line_resp", 256'(line_resp_o), 256'(1'b0));
      check("midreset.rdata", line_rdata_o, 256'd0);
      last_fill   = '0;
      line_read_i = 1'b0;
      @(posedge clk); @(negedge clk);
      check("midreset.no_resp", 256'(line_resp_o), 256'(1'b0));
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check_bus("midreset.idle", 1'b0, 1'b0, 1'b0, 32'h0);
      beats = '{64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738};
      gaps  = '{0, 0, 0, 0};
      do_read("read_after_reset", 32'h0000_2010);

      // Randomized transactions
      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < 4; k++) begin
            beats[k] = {$urandom, $urandom};
            gaps[k]  = int'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 1) == 0) begin
            do_read("rand_read", $urandom);
         end else begin
            do_write("rand_write", $urandom,
                     {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 1)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/line_burst_adapter.md
Name: line_burst_adapter

Overview:
- Memory-side counterpart of the 32-bit-to-256-bit word/line adapter.
- Converts one 256-bit cacheline transaction from the cache/prefetch-cache side into a 4-beat, 64-bit burst to physical memory, and reassembles read bursts into a full line.
- Sits between the prefetch cache's line port and the main-memory burst interface.
- Handles one transaction at a time. Write has priority over read.

Parameters:
- LINE_W, 256, cacheline width in bits. Fixed; the RTL must reject other values.
- BURST_W, 64, memory beat width in bits. LINE_W/BURST_W = 4 beats.
- OFFSET_BITS, 5, low address bits forced to zero on the memory address.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_address_i  input  32  cache-side line address.
- line_read_i  input  1  cache requests line fill. Held until line_resp_o.
- line_write_i  input  1  cache requests line writeback. Held until line_resp_o.
- line_wdata_i  input  256  line to write back.
- line_rdata_o  output  256  assembled fill line.
- line_resp_o  output  1  one-cycle completion pulse.
- mem_address_o  output  32  line-aligned burst address.
- mem_read_o  output  1  burst read request.
- mem_write_o  output  1  burst write request.
- mem_wdata_o  output  64  current write beat.
- mem_rdata_i  input  64  read beat.
- mem_resp_i  input  1  one per beat, read data valid or write beat accepted.

Behaviour:
- States: IDLE, READ, WRITE, DONE. Two-bit beat counter cnt.
- Reset (asynchronous, any state):
  - state=IDLE, cnt=0.
  - mem_read_o=0, mem_write_o=0, line_resp_o=0.
  - mem_address_o=0, line_rdata_o=0, internal line buffer=0.
- IDLE:
  - line_write_i=1 (regardless of line_read_i): latch line_wdata_i into buffer, latch {line_address_i[31:5],5'b0} into mem_address_o, cnt=0, go to WRITE.
  - Else line_read_i=1: latch address the same way, cnt=0, go to READ.
  - mem_resp_i in IDLE or DONE is ignored.
- READ:
  - mem_read_o=1 combinationally from state. First assertion is the cycle after the request is sampled.
  - On each edge with mem_resp_i=1: buffer[64*cnt +: 64] <= mem_rdata_i, cnt++.
  - When cnt==3 and mem_resp_i=1: go to DONE.
  - Beat k (0..3) maps to line bits [64k+63:64k], little-endian beat order.
- WRITE:
  - mem_write_o=1, mem_wdata_o=buffer[64*cnt +: 64].
  - mem_resp_i=1 advances cnt. After the 4th accepted beat, go to DONE.
- DONE: line_resp_o=1 for exactly one cycle, then IDLE.
  - After a read, line_rdata_o=buffer is valid from the DONE cycle and held until the next read completes.
  - line_rdata_o is not disturbed by writes: the fill line is a separate register from the write buffer.
- mem_address_o and mem_wdata_o are stable for the whole burst. No beat gaps are required: mem_resp_i may stall for any number of cycles between beats.
- mem_read_o and mem_write_o are never both 1.
- Cache contract: the cache drops line_read_i/line_write_i in the line_resp_o cycle. A request still high in the following IDLE cycle starts a new transaction.
- Latency with back-to-back mem_resp_i: request sampled at edge 0 → mem_read_o/mem_write_o high in cycles 1..4 → line_resp_o in cycle 5.
- Reset mid-burst: mem_read_o/mem_write_o drop immediately. The partial line is discarded and no line_resp_o is produced.
- Outputs outside READ/WRITE: mem_wdata_o = buffer beat 0; value unused.

Test Plan:
- Reset, then line_read_i at address 0x0000_1234, mem_rdata_i beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with mem_resp_i each cycle → mem_address_o=0x0000_1220, mem_read_o high for 4 cycles, line_rdata_o=0x44..44_33..33_22..22_11..11, line_resp_o a single pulse in cycle 5.
- line_write_i with line_wdata_i={64'hD,64'hC,64'hB,64'hA} at address 0x8000_003F → mem_address_o=0x8000_0020, mem_wdata_o sequence A,B,C,D, one beat per mem_resp_i; line_resp_o after the 4th.
- Write with mem_resp_i gaps (beats accepted at cycles 3, 7, 8, 12) → mem_wdata_o holds each beat until accepted; line_resp_o the cycle after the final beat.
- line_read_i and line_write_i asserted together → write burst first with mem_read_o=0; read begins on a later request; line_rdata_o unchanged by the write.
- rst pulsed after beat 2 of a read → mem_read_o=0 and line_resp_o=0 immediately; a fresh read afterwards returns only new data.
- Stray mem_resp_i in IDLE → no state change, no line_resp_o.
